lsu_store_buffer: RTL
=====================

LSU_STORE_BUFFER -- requirements
Module: lsu_store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of store-buffer entries (power of two, at least 2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 wr_addr / wr_data / wr_size / wr_en  in  32/32/2/1  store request from lsu execute.
REQ-005 rd_addr / rd_size / rd_en  in  32/2/1  load request from lsu execute.
REQ-006 rd_data  out  32  load data to lsu writeback, valid the cycle after an accepted load, right-justified and unextended.
REQ-007 sb_stall  out  1  combinational stall to the hazard detection unit.
REQ-008 mem_addr / mem_wr_data / mem_size  out  32/32/2  single-port data RAM request.
REQ-009 mem_en / mem_we  out  1/1  RAM access enable and write select.
REQ-010 mem_rd_data  in  32  RAM synchronous read data, valid the cycle after mem_en=1 with mem_we=0.

Function
REQ-011 Size encoding: 00 byte, 01 half, 10 word, 11 illegal; accesses are naturally aligned.
REQ-012 Byte mask of an access is derived from addr[1:0] and size; two accesses overlap when addr[31:2] match and their masks intersect.
REQ-013 The buffer is a circular FIFO with head, tail and count; each entry holds addr, size and data, with data bits above the access size zeroed on enqueue.
REQ-014 When sb_stall=0, a store (wr_en=1) is enqueued at tail and is not written to RAM in that cycle.
REQ-015 A load SHALL stall (sb_stall=1) when any valid entry overlaps it and the youngest overlapping entry does not have the same addr and size.
REQ-016 A load whose youngest overlapping entry has the same addr and size is forwarded: that entry's data is registered and driven on rd_data the next cycle, and no RAM read is issued.
REQ-017 A load with no overlapping entry issues a RAM read (mem_en=1, mem_we=0, mem_addr=rd_addr, mem_size=rd_size), and rd_data=mem_rd_data the next cycle.
REQ-018 Port priority: an accepted load owns the RAM port; otherwise, when count>0, the head entry drains (mem_en=1, mem_we=1) and head advances.
REQ-019 While a load stalls on overlap, the port is free to drain, so drain continues until the conflict clears and sb_stall falls.
REQ-020 A store stalls (sb_stall=1) only when count=DEPTH and a drain cannot occur in the same cycle.
REQ-021 Full-buffer store with no load present: drain and enqueue occur together and count is unchanged.
REQ-022 While sb_stall=1, the presented request is ignored; lsu holds it and re-presents it each cycle until sb_stall=0.
REQ-023 Head, tail and forwarding-search pointers wrap modulo DEPTH.
REQ-024 count: increments on enqueue-only, decrements on drain-only, and is unchanged on both or neither.
REQ-025 wr_en=1 together with rd_en=1, size 11, or a misaligned address is illegal and is flagged by a simulation assertion.
REQ-026 rd_data holds its last value in cycles with no load result.

Reset
REQ-027 On rst=1 at a clock edge: count, head and tail go to 0 and all entries become invalid; pending stores are discarded, including during a stall.
REQ-028 During reset: sb_stall=0, mem_en=0, mem_we=0, mem_addr=0, mem_wr_data=0, mem_size=0, rd_data=0; requests are ignored.

Structure
REQ-029 lsu_pkg holds: the size enum (SIZE_B, SIZE_H, SIZE_W), the sb_entry_t struct (addr, size, data), the default DEPTH, and a byte-mask function.
REQ-030 One combinational sub-module, lsu_sb_match, compares one entry with a load and outputs overlap and exact-match; it is instantiated DEPTH times.
REQ-031 A priority select over the lsu_sb_match outputs, ordered from tail back to head, picks the youngest overlapping entry.

Verification
REQ-032 Store word 0xDEADBEEF at 0x100, then on the next cycle load word 0x100 -> no RAM read; rd_data=0xDEADBEEF one cycle later.
REQ-033 Store byte 0xAB at 0x101, then load word 0x100 -> sb_stall=1 until the entry drains (mem_we=1, mem_addr=0x101); then a RAM read is issued and sb_stall=0.
REQ-034 Five word stores back-to-back with DEPTH=4 and no loads -> sb_stall stays 0 (one drain per cycle); count never exceeds 4.
REQ-035 Four stores, then four loads to unrelated addresses, then one store -> store stalls one cycle only if count=4 while a load holds the port; stores drain in FIFO order with head wrapping to 0.
REQ-036 Store half 0x1234 at 0x200, then store half 0x5678 at 0x200, then load half 0x200 -> rd_data=0x00005678 (youngest entry wins).
REQ-037 Three stores enqueued, then rst for one cycle mid-drain -> count=0, mem_en=0; no further RAM writes after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU store buffer.
// Sizes are right-justified; byte masks derive from addr[1:0].
package lsu_pkg;

    localparam int SB_DEPTH = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef struct packed {
        logic [31:0] addr;
        size_e       size;
        logic [31:0] data;
    } sb_entry_t;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] off,
        input size_e      size
    );
        logic [3:0] m;
        case (size)
            SIZE_B:  m = 4'b0001 << off;
            SIZE_H:  m = 4'b0011 << off;
            SIZE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] size_trim(
        input logic [31:0] data,
        input size_e       size
    );
        logic [31:0] r;
        case (size)
            SIZE_B:  r = {24'b0, data[7:0]};
            SIZE_H:  r = {16'b0, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(
        input logic [1:0] off,
        input logic [1:0] size
    );
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = !off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_sb_match.sv
// Compares one store-buffer entry against a load request.
module lsu_sb_match
    import lsu_pkg::*;
(
    input  logic        valid,
    input  sb_entry_t   entry,
    input  logic [31:0] ld_addr,
    input  size_e       ld_size,
    output logic        overlap,
    output logic        exact
);

    logic [3:0] ent_mask;
    logic [3:0] ld_mask;
    logic       same_word;

    always_comb begin
        ent_mask  = byte_mask(entry.addr[1:0], entry.size);
        ld_mask   = byte_mask(ld_addr[1:0], ld_size);
        same_word = (entry.addr[31:2] == ld_addr[31:2]);
        overlap   = valid && same_word && |(ent_mask & ld_mask);
        exact     = overlap && (entry.addr == ld_addr)
                    && (entry.size == ld_size);
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// Circular store buffer with load forwarding and a shared
// single-port RAM: loads own the port, otherwise head drains.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_size,
    input  logic        wr_en,
    input  logic [31:0] rd_addr,
    input  logic [1:0]  rd_size,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        sb_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [1:0]  mem_size,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [31:0] mem_rd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      rd_hold_q, rd_hold_d;
    logic             ram_pend_q, ram_pend_d;

    logic [DEPTH-1:0] ovl, exact;
    logic [PW-1:0]    srch_idx, hit_idx;
    logic             hit_any, hit_exact;
    logic             ld_req, ld_stall, ld_fwd, ld_ram;
    logic             st_stall, drain, enq;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        lsu_sb_match u_match (
            .valid   (valid_q[i]),
            .entry   (ent_q[i]),
            .ld_addr (rd_addr),
            .ld_size (size_e'(rd_size)),
            .overlap (ovl[i]),
            .exact   (exact[i])
        );
    end

    // Walk from the youngest entry (tail-1) back to head.
    always_comb begin
        hit_any   = 1'b0;
        hit_exact = 1'b0;
        hit_idx   = '0;
        srch_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            srch_idx = tail_q - PW'(k + 1);
            if (!hit_any && ovl[srch_idx]) begin
                hit_any   = 1'b1;
                hit_exact = exact[srch_idx];
                hit_idx   = srch_idx;
            end
        end
    end

    always_comb begin
        ld_req   = rd_en && !rst;
        ld_stall = ld_req && hit_any && !hit_exact;
        ld_fwd   = ld_req && hit_exact;
        ld_ram   = ld_req && !hit_any;
        drain    = !rst && (count_q != '0)
                   && !(ld_fwd || ld_ram);
        st_stall = !rst && wr_en
                   && (count_q == CW'(DEPTH)) && !drain;
        sb_stall = ld_stall || st_stall;
        enq      = !rst && wr_en && !sb_stall;
    end

    always_comb begin
        ent_d      = ent_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_hold_d  = rd_hold_q;
        ram_pend_d = ld_ram;
        if (ram_pend_q) rd_hold_d = mem_rd_data;
        if (ld_fwd) rd_hold_d = ent_q[hit_idx].data;
        // Clear before set: a full buffer drains and refills one slot.
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (enq) begin
            ent_d[tail_q].addr = wr_addr;
            ent_d[tail_q].size = size_e'(wr_size);
            ent_d[tail_q].data =
                size_trim(wr_data, size_e'(wr_size));
            valid_d[tail_q]    = 1'b1;
            tail_d             = tail_q + 1'b1;
        end
        unique case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_size    = '0;
        if (ld_ram) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
            mem_size = rd_size;
        end else if (drain) begin
            mem_en      = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = ent_q[head_q].addr;
            mem_wr_data = ent_q[head_q].data;
            mem_size    = ent_q[head_q].size;
        end
        rd_data = rst ? '0
                : (ram_pend_q ? mem_rd_data : rd_hold_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_hold_q  <= '0;
            ram_pend_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_hold_q  <= rd_hold_d;
            ram_pend_q <= ram_pend_d;
        end
        ent_q <= ent_d;
    end

    a_no_dual_req: assert property (
        @(posedge clk) disable iff (rst)
        !(wr_en && rd_en));
    a_wr_legal: assert property (
        @(posedge clk) disable iff (rst)
        wr_en |-> is_legal(wr_addr[1:0], wr_size));
    a_rd_legal: assert property (
        @(posedge clk) disable iff (rst)
        rd_en |-> is_legal(rd_addr[1:0], rd_size));

endmodule
